// File: rtl/bv4_mul_seq.sv
// Sequenced GF((2^2)^2) normal-basis multiplier: one shared GF(4) multiplier
// is stepped over the high, low and cross terms across three cycles.
module bv4_mul_seq (
    input  logic       in_clock,
    input  logic       in_reset,
    input  logic       in_valid,
    output logic       out_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic       out_valid,
    input  logic       in_ready,
    output logic [3:0] out_c
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] MUL_H = 3'd1;
    localparam logic [2:0] MUL_L = 3'd2;
    localparam logic [2:0] MUL_E = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [1:0] ph_q;
    logic [1:0] pl_q;
    logic [1:0] mul_x;
    logic [1:0] mul_y;
    logic [1:0] mul_p;
    logic       accept;

    // GF(4) multiply in normal basis {W^2, W}; 2'b11 is the identity.
    function automatic logic [1:0] bv2_mul(input logic [1:0] x, input logic [1:0] y);
        logic e;
        e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
        return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
    endfunction

    function automatic logic [1:0] scale_n(input logic [1:0] x);
        return {x[0], x[0] ^ x[1]};
    endfunction

    assign out_ready = (state == IDLE) | ((state == DONE) & in_ready);
    assign accept    = in_valid & out_ready;
    assign out_valid = (state == DONE);

    // Operands are forced to zero outside the multiply states so the shared
    // multiplier does not toggle on stale data.
    always_comb begin
        mul_x = 2'b00;
        mul_y = 2'b00;
        case (state)
            MUL_H: begin
                mul_x = a_q[3:2];
                mul_y = b_q[3:2];
            end
            MUL_L: begin
                mul_x = a_q[1:0];
                mul_y = b_q[1:0];
            end
            MUL_E: begin
                mul_x = a_q[3:2] ^ a_q[1:0];
                mul_y = b_q[3:2] ^ b_q[1:0];
            end
            default: begin
                mul_x = 2'b00;
                mul_y = 2'b00;
            end
        endcase
    end

    assign mul_p = bv2_mul(mul_x, mul_y);

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = accept ? MUL_H : IDLE;
            MUL_H:   state_nxt = MUL_L;
            MUL_L:   state_nxt = MUL_E;
            MUL_E:   state_nxt = DONE;
            DONE: begin
                if (!in_ready)
                    state_nxt = DONE;
                else if (in_valid)
                    state_nxt = MUL_H;
                else
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state <= IDLE;
            a_q   <= 4'h0;
            b_q   <= 4'h0;
            ph_q  <= 2'b00;
            pl_q  <= 2'b00;
            out_c <= 4'h0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q <= in_a;
                b_q <= in_b;
            end
            if (state == MUL_H)
                ph_q <= mul_p;
            if (state == MUL_L)
                pl_q <= mul_p;
            // The cross term is used live, it is never registered.
            if (state == MUL_E)
                out_c <= {ph_q ^ scale_n(mul_p), pl_q ^ scale_n(mul_p)};
        end
    end

endmodule

// File: tb/tb_bv4_mul_seq.sv
// Bench for bv4_mul_seq: table-driven GF(4) reference, cycle-level handshake
// model checked every cycle, and directed vectors with literal products.
module tb_bv4_mul_seq;

    logic       in_clock = 1'b0;
    logic       in_reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_c;

    bv4_mul_seq dut (
        .in_clock (in_clock),
        .in_reset (in_reset),
        .in_valid (in_valid),
        .out_ready(out_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .in_ready (in_ready),
        .out_c    (out_c)
    );

    always #5 in_clock = ~in_clock;

    int vectors    = 0;
    int miscompares = 0;
    bit check_en   = 1'b0;

    // GF(4) multiplication table, index = 4*x + y; 3 is the identity.
    logic [1:0] gf4_tbl [0:15] = '{2'd0, 2'd0, 2'd0, 2'd0,
                                   2'd0, 2'd2, 2'd3, 2'd1,
                                   2'd0, 2'd3, 2'd1, 2'd2,
                                   2'd0, 2'd1, 2'd2, 2'd3};

    function automatic logic [1:0] gf4(input logic [1:0] x, input logic [1:0] y);
        return gf4_tbl[{x, y}];
    endfunction

    function automatic logic [3:0] gf16(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] ph, pl, pe, spe;
        ph  = gf4(a[3:2], b[3:2]);
        pl  = gf4(a[1:0], b[1:0]);
        pe  = gf4(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]);
        spe = gf4(pe, 2'b10);
        return {ph ^ spe, pl ^ spe};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase counts cycles since accept (0 idle, 1..3 busy, 4 result held).
    int         m_phase = 0;
    logic [3:0] m_a = 4'h0;
    logic [3:0] m_b = 4'h0;
    logic [3:0] m_c = 4'h0;

    always @(posedge in_clock) begin
        if (in_reset) begin
            m_phase <= 0;
            m_c     <= 4'h0;
        end else if (m_phase == 0 || (m_phase == 4 && in_ready)) begin
            if (in_valid) begin
                m_a     <= in_a;
                m_b     <= in_b;
                m_phase <= 1;
            end else begin
                m_phase <= 0;
            end
        end else if (m_phase == 3) begin
            m_c     <= gf16(m_a, m_b);
            m_phase <= 4;
        end else if (m_phase != 4) begin
            m_phase <= m_phase + 1;
        end
    end

    always @(negedge in_clock) begin
        if (check_en) begin
            check("model_out_valid", {3'b000, out_valid}, {3'b000, m_phase == 4});
            check("model_out_ready", {3'b000, out_ready},
                  {3'b000, (m_phase == 0) || (m_phase == 4 && in_ready)});
            check("model_out_c", out_c, m_c);
        end
    end

    task automatic step();
        @(posedge in_clock);
        #1;
    endtask

    task automatic do_mul(input logic [3:0] a, input logic [3:0] b, input logic rdy,
                          input logic [3:0] exp);
        int n;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        in_ready = rdy;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            step();
            n++;
        end
        check("latency", n[3:0], 4'd3);
        check("product", out_c, exp);
    endtask

    initial begin
        int cnt;
        in_reset = 1'b1;
        in_valid = 1'b0;
        in_ready = 1'b1;
        in_a     = 4'h0;
        in_b     = 4'h0;
        step();
        check_en = 1'b1;
        step();
        in_reset = 1'b0;
        check("reset_out_valid", {3'b000, out_valid}, 4'h0);
        check("reset_out_c", out_c, 4'h0);
        check("reset_out_ready", {3'b000, out_ready}, 4'h1);
        repeat (10) step();
        check("idle_out_ready", {3'b000, out_ready}, 4'h1);

        // Literal products pin both the model and the DUT.
        check("model_2x2", gf16(4'h2, 4'h2), 4'hE);
        check("model_5x3", gf16(4'h5, 4'h3), 4'h1);
        do_mul(4'h2, 4'h2, 1'b1, 4'hE);
        step();
        check("back_to_idle", {3'b000, out_ready & ~out_valid}, 4'h1);
        do_mul(4'hB, 4'hF, 1'b1, 4'hB); step();
        do_mul(4'hB, 4'h0, 1'b1, 4'h0); step();
        do_mul(4'h5, 4'h3, 1'b1, 4'h1); step();
        do_mul(4'h3, 4'h5, 1'b1, 4'h1); step();

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_mul(a[3:0], b[3:0], 1'b1, gf16(a[3:0], b[3:0]));
                step();
            end
        end

        // Backpressure, then drain-and-accept in the same DONE cycle.
        do_mul(4'h2, 4'h2, 1'b0, 4'hE);
        repeat (4) begin
            step();
            check("bp_out_valid", {3'b000, out_valid}, 4'h1);
            check("bp_out_c", out_c, 4'hE);
            check("bp_out_ready", {3'b000, out_ready}, 4'h0);
        end
        in_a = 4'hF;
        in_b = 4'h7;
        in_valid = 1'b1;
        in_ready = 1'b1;
        #1;
        check("drain_accept_ready", {3'b000, out_ready}, 4'h1);
        step();
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 10) begin
            step();
            cnt++;
        end
        check("drain_latency", cnt[3:0], 4'd3);
        check("drain_product", out_c, 4'h7);
        step();

        // Streaming: accepts every 4 cycles, one valid cycle per accept.
        in_a = 4'h5;
        in_b = 4'h3;
        in_valid = 1'b1;
        in_ready = 1'b1;
        cnt = 0;
        repeat (20) begin
            step();
            if (out_valid) cnt++;
        end
        check("stream_valid_count", cnt[3:0], 4'd5);
        in_valid = 1'b0;
        step();

        // Reset during MUL_L aborts the pair.
        in_a = 4'hB;
        in_b = 4'hB;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        in_reset = 1'b1;
        step();
        in_reset = 1'b0;
        check("abort_out_valid", {3'b000, out_valid}, 4'h0);
        check("abort_out_c", out_c, 4'h0);
        check("abort_out_ready", {3'b000, out_ready}, 4'h1);
        repeat (8) begin
            step();
            check("abort_no_result", {3'b000, out_valid}, 4'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
